// File: rtl/arrow_lane.sv
// arrow_lane: scrolling lane of upcoming arrow codes, judges button presses against slot 0 and keeps score.
// Optional combo counter and bonus scoring under macro ARROW_LANE_COMBO_EN.
module arrow_lane #(
   parameter int DEPTH       = 8,
   parameter int CODE_W      = 4,
   parameter int ARROW_BASE  = 10,
   parameter int NUM_ARROWS  = 5,
   parameter int SCORE_W     = 16,
   parameter int HIT_POINTS  = 4,
   parameter int STATE_BITS  = 2,
   parameter logic [STATE_BITS:0] STATE_RESET = '0,
   parameter logic [STATE_BITS:0] STATE_PLAY  = (STATE_BITS+1)'(1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [STATE_BITS:0]       state,
   input  logic                      beat,
   input  logic [CODE_W-1:0]         random_arrow,
   input  logic                      spawn,
   input  logic [NUM_ARROWS-1:0]     btn,
   output logic [DEPTH*CODE_W-1:0]   lane,
   output logic                      hit,
   output logic                      miss,
   output logic [SCORE_W-1:0]        score,
   output logic [7:0]                combo
);

   function automatic logic code_valid(input logic [CODE_W-1:0] c);
      return (int'(c) >= ARROW_BASE) && (int'(c) <= ARROW_BASE + NUM_ARROWS - 1);
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   logic [CODE_W-1:0]     lane_q [DEPTH];
   logic                  judged_q;
   logic [NUM_ARROWS-1:0] btn_q;
   logic [SCORE_W-1:0]    score_q;
   logic                  hit_q;
   logic                  miss_q;

   logic                  clear;
   logic                  run;
   logic [NUM_ARROWS-1:0] press;
   logic                  slot0_valid;
   logic [NUM_ARROWS-1:0] slot0_onehot;
   logic                  judge;
   logic                  good;
   logic                  depart_miss;
   logic [CODE_W-1:0]     entry_code;
   logic [SCORE_W-1:0]    points;

   assign clear = rst || (state == STATE_RESET);
   assign run   = (state == STATE_PLAY);
   assign press = btn & ~btn_q;

   assign slot0_valid  = code_valid(lane_q[0]);
   assign slot0_onehot = NUM_ARROWS'(1) << (int'(lane_q[0]) - ARROW_BASE);

   // A press counts only once per arrow; a beat-coincident press is judged before the shift.
   assign judge       = run && (press != '0) && slot0_valid && !judged_q;
   assign good        = judge && (press == slot0_onehot);
   assign depart_miss = run && beat && slot0_valid && !judged_q && !judge;

   assign entry_code = (spawn && code_valid(random_arrow)) ? random_arrow : '0;

`ifdef ARROW_LANE_COMBO_EN
   logic [7:0] combo_q;

   assign points = (combo_q >= 8'd8) ? SCORE_W'(2 * HIT_POINTS) : SCORE_W'(HIT_POINTS);
   assign combo  = combo_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         combo_q <= '0;
      end else if (good) begin
         combo_q <= (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
      end else if ((judge && !good) || depart_miss) begin
         combo_q <= '0;
      end
   end
`else
   assign points = SCORE_W'(HIT_POINTS);
   assign combo  = '0;
`endif

   // Button history tracks every cycle, even while frozen, so resume sees no stale edge.
   always_ff @(posedge clk) begin
      if (clear) btn_q <= '0;
      else       btn_q <= btn;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int k = 0; k < DEPTH; k++) lane_q[k] <= '0;
         judged_q <= 1'b0;
         score_q  <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         hit_q  <= good;
         miss_q <= (judge && !good) || depart_miss;
         if (good) score_q <= sat_add(score_q, points);
         if (run && beat) begin
            for (int k = 0; k < DEPTH-1; k++) lane_q[k] <= lane_q[k+1];
            lane_q[DEPTH-1] <= entry_code;
            judged_q        <= 1'b0;
         end else if (judge) begin
            judged_q <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_pack
      assign lane[g*CODE_W +: CODE_W] = lane_q[g];
   end

   assign hit   = hit_q;
   assign miss  = miss_q;
   assign score = score_q;

endmodule

// File: tb/tb_arrow_lane.sv
// Directed table-driven bench for arrow_lane: scroll, judging, freeze, saturation and reset.
module tb_arrow_lane;

   localparam logic [2:0] ST_RESET = 3'd0;
   localparam logic [2:0] ST_PLAY  = 3'd1;
   localparam logic [2:0] ST_PAUSE = 3'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic        beat;
   logic [3:0]  random_arrow;
   logic        spawn;
   logic [4:0]  btn;
   logic [31:0] lane;
   logic        hit;
   logic        miss;
   logic [15:0] score;
   logic [7:0]  combo;

   int checks   = 0;
   int failures = 0;

   arrow_lane dut (
      .clk(clk), .rst(rst), .state(state), .beat(beat), .random_arrow(random_arrow),
      .spawn(spawn), .btn(btn), .lane(lane), .hit(hit), .miss(miss), .score(score), .combo(combo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       beat;
      logic       spawn;
      logic [3:0] arrow;
      logic [4:0] btn;
      logic       hit;
      logic       miss;
      int         score;
      int         slot0;
      int         slot7;
   } vec_t;

   vec_t vecs [28];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic b, input logic s, input logic [3:0] a, input logic [4:0] bt,
                               input logic h, input logic m, input int sc, input int s0, input int s7);
      vec_t v;
      v.beat = b; v.spawn = s; v.arrow = a; v.btn = bt;
      v.hit = h; v.miss = m; v.score = sc; v.slot0 = s0; v.slot7 = s7;
      return v;
   endfunction

   int slot0_v, slot7_v;
   assign slot0_v = int'(lane[3:0]);
   assign slot7_v = int'(lane[31:28]);

   initial begin
      // Fill: 8 beats of code 12, then hit / held / re-press / misses / wrong press / simultaneous hit
      for (int i = 0; i < 7; i++) vecs[i] = mk(1, 1, 12, 5'b00000, 0, 0, 0, 0, 12);
      vecs[7]  = mk(1, 1, 12, 5'b00000, 0, 0, 0, 12, 12);
      vecs[8]  = mk(0, 1, 12, 5'b00100, 1, 0, 4, 12, 12);
      vecs[9]  = mk(0, 1, 12, 5'b00100, 0, 0, 4, 12, 12);
      vecs[10] = mk(0, 1, 12, 5'b00000, 0, 0, 4, 12, 12);
      vecs[11] = mk(0, 1, 12, 5'b00100, 0, 0, 4, 12, 12);
      vecs[12] = mk(1, 0, 12, 5'b00000, 0, 0, 4, 12, 0);
      vecs[13] = mk(1, 1, 11, 5'b00000, 0, 1, 4, 12, 11);
      vecs[14] = mk(1, 1, 15, 5'b00000, 0, 1, 4, 12, 0);
      vecs[15] = mk(0, 0, 0,  5'b00011, 0, 1, 4, 12, 0);
      vecs[16] = mk(1, 1, 14, 5'b00000, 0, 0, 4, 12, 14);
      vecs[17] = mk(0, 0, 0,  5'b00100, 1, 0, 8, 12, 14);
      vecs[18] = mk(1, 0, 0,  5'b00100, 0, 0, 8, 12, 0);
      vecs[19] = mk(1, 0, 0,  5'b00000, 0, 1, 8, 12, 0);
      vecs[20] = mk(1, 0, 0,  5'b00000, 0, 1, 8, 12, 0);
      vecs[21] = mk(1, 0, 0,  5'b00000, 0, 1, 8, 0, 0);
      vecs[22] = mk(1, 0, 0,  5'b00000, 0, 0, 8, 11, 0);
      vecs[23] = mk(0, 0, 0,  5'b00001, 0, 1, 8, 11, 0);
      vecs[24] = mk(1, 0, 0,  5'b00000, 0, 0, 8, 0, 0);
      vecs[25] = mk(0, 0, 0,  5'b00100, 0, 0, 8, 0, 0);
      vecs[26] = mk(1, 0, 0,  5'b00000, 0, 0, 8, 14, 0);
      vecs[27] = mk(1, 0, 0,  5'b10000, 1, 0, 12, 0, 0);

      rst = 1'b1; state = ST_PLAY; beat = 0; random_arrow = 0; spawn = 0; btn = 0;
      step(); step();
      chk("reset_lane", int'(lane), 0);
      chk("reset_score", int'(score), 0);
      chk("reset_hit", int'(hit), 0);
      chk("reset_miss", int'(miss), 0);
      chk("reset_combo", int'(combo), 0);
      rst = 1'b0;

      for (int i = 0; i < 28; i++) begin
         beat = vecs[i].beat; spawn = vecs[i].spawn; random_arrow = vecs[i].arrow; btn = vecs[i].btn;
         step();
         chk($sformatf("v%0d_hit", i), int'(hit), int'(vecs[i].hit));
         chk($sformatf("v%0d_miss", i), int'(miss), int'(vecs[i].miss));
         chk($sformatf("v%0d_score", i), int'(score), vecs[i].score);
         chk($sformatf("v%0d_slot0", i), slot0_v, vecs[i].slot0);
         chk($sformatf("v%0d_slot7", i), slot7_v, vecs[i].slot7);
      end

      // Freeze: beats and a press while paused change nothing; held button gives no edge on resume
      beat = 1; spawn = 1; random_arrow = 13; btn = 0;
      step();
      chk("pre_freeze_slot7", slot7_v, 13);
      state = ST_PAUSE; random_arrow = 12;
      for (int i = 0; i < 3; i++) begin
         btn = (i == 1) ? 5'b01000 : btn;
         step();
      end
      chk("freeze_slot7", slot7_v, 13);
      chk("freeze_slot6", int'(lane[27:24]), 0);
      chk("freeze_score", int'(score), 12);
      beat = 0; state = ST_PLAY;
      for (int i = 0; i < 4; i++) begin
         beat = 1; spawn = 0; step();
      end
      chk("resume_slot3", int'(lane[15:12]), 13);

      // Saturation: fill with 12, then beat+press every other cycle
      btn = 0;
      for (int i = 0; i < 8; i++) begin
         beat = 1; spawn = 1; random_arrow = 12; step();
      end
      begin
         int hit_bad = 0;
         for (int n = 0; n < 16390; n++) begin
            beat = 1; btn = 5'b00100; step();
            if (hit !== 1'b1 || miss !== 1'b0) hit_bad++;
            beat = 0; btn = 0; step();
`ifndef ARROW_LANE_COMBO_EN
            if (n == 16379) chk("score_pre_sat", int'(score), 65532);
`endif
         end
         chk("sat_hits_all_strobed", hit_bad, 0);
      end
      chk("score_saturated", int'(score), 65535);

      // Mid-game reset with full lane and a correct press pending
      rst = 1; btn = 5'b00100; step();
      chk("midrst_lane", int'(lane), 0);
      chk("midrst_score", int'(score), 0);
      chk("midrst_hit", int'(hit), 0);
      chk("midrst_miss", int'(miss), 0);
      rst = 0; btn = 0;
      beat = 1; spawn = 1; random_arrow = 10; step();
      chk("stateload_slot7", slot7_v, 10);
      beat = 0; state = ST_RESET; step();
      chk("state_reset_lane", int'(lane), 0);
      state = ST_PLAY;

      // Combo: 9 consecutive hits, the 9th worth double
      for (int i = 0; i < 8; i++) begin
         beat = 1; spawn = 1; random_arrow = 12; step();
      end
      for (int n = 0; n < 9; n++) begin
         beat = 1; btn = 5'b00100; step();
         beat = 0; btn = 0; step();
      end
`ifdef ARROW_LANE_COMBO_EN
      chk("combo_score", int'(score), 40);
      chk("combo_count", int'(combo), 9);
      beat = 1; btn = 0; step();
      chk("combo_miss_clear", int'(combo), 0);
`else
      chk("combo_score", int'(score), 36);
      chk("combo_tied_zero", int'(combo), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
